// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: IMEM port sequencer with 2-entry fetch queue and loader port.
// Build option IMEM_FETCH_STARVE_GUARD_EN bounds how long the loader can starve fetch.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    output logic        running
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      state, state_nx;
    logic [31:0] pc;
    logic [31:0] q_instr [2];
    logic [31:0] q_pc [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  count;
    logic        infl_valid;
    logic [31:0] infl_pc;

    logic        flush, fetch_elig, fetch_go, guard_force;
    logic        resp_ok, pop, push, pop_q;
    logic [1:0]  credit;
    logic        unused_bits;

    assign running    = (state != IDLE);
    assign flush      = redir_valid && (state != IDLE);
    assign credit     = count + {1'b0, infl_valid};
    assign fetch_elig = (state == RUN) && (credit < 2'd2) && !redir_valid;
    assign ld_ready   = ld_valid && !guard_force;
    assign fetch_go   = fetch_elig && !ld_ready;

    // Read data arrives the cycle after issue; an empty queue passes it straight through.
    assign resp_ok  = infl_valid && !flush;
    assign if_valid = (count != 2'd0) || resp_ok;
    assign if_instr = (count != 2'd0) ? q_instr[rd_ptr] : mem_rdata;
    assign if_pc    = (count != 2'd0) ? q_pc[rd_ptr] : infl_pc;
    assign pop      = if_valid && if_ready;
    assign pop_q    = pop && (count != 2'd0);
    assign push     = resp_ok && !((count == 2'd0) && pop);

`ifdef IMEM_FETCH_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 2);
    logic [CW-1:0] starve_cnt;

    assign guard_force = fetch_elig && (starve_cnt == CW'(STARVE_LIMIT));
    assign unused_bits = ^{ld_addr[1:0], redir_pc[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!fetch_elig || fetch_go) begin
            starve_cnt <= '0;
        end else if (ld_ready) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign guard_force = 1'b0;
    assign unused_bits = ^{ld_addr[1:0], redir_pc[1:0], STARVE_LIMIT};
`endif

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (1'b1)
            ld_ready: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {ld_addr[31:2], 2'b00};
                mem_wdata = ld_data;
            end
            fetch_go: begin
                mem_en   = 1'b1;
                mem_addr = pc;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start && !stop) state_nx = RUN;
            RUN:     if (stop) state_nx = DRAIN;
            DRAIN:   if (!infl_valid && count == 2'd0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            count      <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            infl_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            infl_valid <= fetch_go;
            if (redir_valid) begin
                pc <= {redir_pc[31:2], 2'b00};
            end else if (fetch_go) begin
                pc <= pc + 32'd4;
            end
            if (flush) begin
                count  <= '0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (push) wr_ptr <= ~wr_ptr;
                if (pop_q) rd_ptr <= ~rd_ptr;
                count <= count + {1'b0, push} - {1'b0, pop_q};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fetch_go) infl_pc <= pc;
        if (push && !flush) begin
            q_instr[wr_ptr] <= mem_rdata;
            q_pc[wr_ptr]    <= infl_pc;
        end
    end
endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch controller that sequences the instruction memory (IMEM) and shares its single port between the core's fetch path and a program loader. It owns the fetch PC, issues reads, absorbs the one-cycle read latency into a 2-entry instruction queue with a valid/ready handshake toward decode, and handles redirects (branches/jumps) by flushing. It sits between the IMEM array and the decode stage.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC loaded at reset (byte address, word aligned)
- STARVE_LIMIT, 4, consecutive loader grants tolerated while fetch is pending (guard build only)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse: IDLE -> RUN
- stop  in  1  pulse: RUN -> DRAIN
- redir_valid  in  1  redirect request
- redir_pc  in  32  redirect target; bits [1:0] forced to 0
- ld_valid  in  1  loader write request
- ld_addr  in  32  loader byte address; bits [1:0] ignored
- ld_data  in  32  loader write data
- ld_ready  out  1  loader write accepted this cycle
- mem_en  out  1  IMEM access strobe
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  IMEM byte address (word index = mem_addr >> 2)
- mem_wdata  out  32  IMEM write data
- mem_rdata  in  32  IMEM read data, valid the cycle after a read strobe
- if_valid  out  1  queue head valid
- if_instr  out  32  queue head instruction
- if_pc  out  32  queue head PC
- if_ready  in  1  decode accepts head
- running  out  1  state != IDLE

## Operation
- States: IDLE (reset), RUN, DRAIN.
  - IDLE: no fetch reads. start -> RUN. redir_valid loads pc (sets boot PC).
  - RUN: fetch issues reads. stop -> DRAIN (stop wins over start).
  - DRAIN: no new reads; -> IDLE once in-flight read has landed and queue is empty. Decode keeps popping.
- Fetch issue (RUN only): read at pc when (queue count + in-flight) < 2, no redirect this cycle, and loader not granted. On issue, pc <= pc + 4 (32-bit wrap, 0xFFFF_FFFC -> 0).
- Response: cycle after a read, {mem_rdata, issued PC} pushed to tail unless killed by redirect. The credit rule makes overflow impossible.
- Pop: if_valid && if_ready removes head. Push and pop in the same cycle keep count unchanged.
- Redirect (RUN/DRAIN): queue cleared, in-flight read marked killed (its data dropped), pc <= {redir_pc[31:2],2'b00}. No read is issued in the redirect cycle. First read of the target is issued the next cycle.
- Arbitration: loader has fixed priority. ld_ready = ld_valid && !guard_force. A granted write drives mem_en=1, mem_we=1, mem_addr={ld_addr[31:2],2'b00}, mem_wdata=ld_data. Legal in every state.
- Redirect and loader grant in the same cycle: both take effect (PC update plus write).

## Timing
- Reset values: state IDLE, pc=RESET_PC, queue empty, if_valid=0, mem_en=0, mem_we=0, ld_ready=0, running=0, starve counter 0. Reset mid-operation discards queue and in-flight data immediately.
- Fetch latency: read issued cycle N -> if_valid at N+1 (empty queue).
- start at N -> first read at N+1, first if_valid at N+2.
- Redirect at N -> target read N+1, target if_valid N+2. if_valid=0 at N+1.
- Sustained throughput: 1 instr/cycle with if_ready=1 and no loader traffic.
- ld_ready is combinational from ld_valid and registered guard state. mem_* are combinational from state and inputs.

## Configuration
- IMEM_FETCH_STARVE_GUARD_EN defined: a counter tracks consecutive loader grants while a fetch issue is otherwise eligible. When it reaches STARVE_LIMIT, the next such cycle forces ld_ready=0 and grants fetch. The counter clears on any fetch grant or when fetch is not eligible.
- Not defined: strict loader priority, no counter, and fetch can starve indefinitely.

## Test plan
- Reset then start, if_ready=1, IMEM word i = 0x1000_0000+i: if_pc 0,4,8,… with matching instr every cycle from start+2.
- if_ready=0 for 5 cycles in RUN: exactly 2 entries held (pc 0,4), no further mem_en, no loss on release.
- redir_valid with redir_pc=0x23 while 1 entry queued and 1 in flight: both dropped, next if_pc=0x20.
- Loader writes 0xDEAD_BEEF to 0x10 in IDLE, then start with RESET_PC=0x10: first if_instr=0xDEAD_BEEF.
- ld_valid held high 10 cycles in RUN: guard build grants fetch on every 5th eligible cycle (STARVE_LIMIT=4), ld_ready low in those cycles; non-guard build gives zero fetches.
- stop with 1 in flight and 1 queued, if_ready=1: running stays high until both are popped, then falls. rst_n low mid-RUN clears if_valid immediately.
